// File: rtl/pattern_scan_arb.sv
// Two-requester arbiter around one shared serial "001" detector; counts matches per 8-bit word.
// Optional: define ROUND_ROBIN_EN for round-robin arbitration (default: requester 0 has fixed priority).
module pattern_scan_arb (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0,
    input  logic [7:0] data0,
    input  logic       req1,
    input  logic [7:0] data1,
    output logic       ack0,
    output logic       ack1,
    output logic [2:0] count,
    output logic       busy
);

    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = 3;
    localparam int unsigned BIT_W  = 3;

    typedef enum logic [1:0] {IDLE, SHIFT, FLUSH, DONE} state_t;
    typedef enum logic [1:0] {S0, S1, S2, S3} det_t;

    state_t              state, state_next;
    det_t                det, det_next;
    logic [DATA_W-1:0]   shreg;
    logic [BIT_W-1:0]    bitcnt;
    logic [CNT_W-1:0]    acc;
    logic                owner;
    logic                grant1;
    logic                load, shift_en, flush, match;
`ifdef ROUND_ROBIN_EN
    logic                last_owner;
`endif

    // Controller and detector next-state, plus datapath strobes.
    always_comb begin
        state_next = state;
        det_next   = det;
        load       = 1'b0;
        shift_en   = 1'b0;
        flush      = 1'b0;
`ifdef ROUND_ROBIN_EN
        grant1     = req1 && (!req0 || !last_owner);
`else
        grant1     = req1 && !req0;
`endif
        match      = ((state == SHIFT) || (state == FLUSH)) && (det == S3);
        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    load       = 1'b1;
                    det_next   = S0;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                shift_en = 1'b1;
                case (det)
                    S0:      det_next = shreg[DATA_W-1] ? S0 : S1;
                    S1:      det_next = shreg[DATA_W-1] ? S0 : S2;
                    S2:      det_next = shreg[DATA_W-1] ? S3 : S2;
                    default: det_next = S0;
                endcase
                if (bitcnt == BIT_W'(DATA_W - 1)) begin
                    state_next = FLUSH;
                end
            end
            FLUSH: begin
                flush      = 1'b1;
                det_next   = S0;
                state_next = DONE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            det   <= S0;
        end else begin
            state <= state_next;
            det   <= det_next;
        end
    end

    // Shift register, accumulator and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shreg  <= '0;
            bitcnt <= '0;
            acc    <= '0;
            owner  <= 1'b0;
            count  <= '0;
            ack0   <= 1'b0;
            ack1   <= 1'b0;
            busy   <= 1'b0;
`ifdef ROUND_ROBIN_EN
            last_owner <= 1'b1;
`endif
        end else begin
            busy <= (state_next != IDLE);
            ack0 <= flush && !owner;
            ack1 <= flush && owner;
            if (load) begin
                shreg  <= grant1 ? data1 : data0;
                bitcnt <= '0;
                acc    <= '0;
                owner  <= grant1;
`ifdef ROUND_ROBIN_EN
                last_owner <= grant1;
`endif
            end
            if (shift_en) begin
                shreg  <= {shreg[DATA_W-2:0], 1'b0};
                bitcnt <= bitcnt + BIT_W'(1);
                acc    <= acc + CNT_W'(match);
            end
            if (flush) begin
                count <= acc + CNT_W'(match);
            end
        end
    end

endmodule

// File: tb/tb_pattern_scan_arb.sv
// Directed bench for pattern_scan_arb; follows ROUND_ROBIN_EN the same way as the design.
module tb_pattern_scan_arb;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       req0 = 1'b0;
    logic [7:0] data0 = 8'h00;
    logic       req1 = 1'b0;
    logic [7:0] data1 = 8'h00;
    logic       ack0, ack1, busy;
    logic [2:0] count;

    int checks = 0;
    int fails  = 0;

    pattern_scan_arb dut (
        .clk   (clk),
        .reset (reset),
        .req0  (req0),
        .data0 (data0),
        .req1  (req1),
        .data1 (data1),
        .ack0  (ack0),
        .ack1  (ack1),
        .count (count),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    // Stimulus only: one request, observe 14 edges (edge 1 samples req).
    task automatic run_scan(input logic which, input logic [7:0] d,
                            output int ack_edge, output logic [2:0] cnt,
                            output logic other_ack, output int ack_width,
                            output int busy_cycles, output logic [2:0] cnt_end);
        ack_edge = 0; cnt = 3'd0; other_ack = 1'b0; ack_width = 0; busy_cycles = 0;
        if (which) begin req1 = 1'b1; data1 = d; end
        else       begin req0 = 1'b1; data0 = d; end
        for (int e = 1; e <= 14; e++) begin
            @(posedge clk);
            @(negedge clk);
            if (busy) busy_cycles++;
            if ((which ? ack1 : ack0) === 1'b1) begin
                ack_width++;
                if (ack_edge == 0) begin
                    ack_edge = e;
                    cnt = count;
                    if (which) req1 = 1'b0; else req0 = 1'b0;
                end
            end
            if ((which ? ack0 : ack1) !== 1'b0) other_ack = 1'b1;
        end
        cnt_end = count;
    endtask

    task automatic test_reset();
        #1;
        checks++; if (ack0 !== 1'b0) begin fails++; $display("FAIL reset_ack0: got %b expected 0", ack0); end
        checks++; if (ack1 !== 1'b0) begin fails++; $display("FAIL reset_ack1: got %b expected 0", ack1); end
        checks++; if (count !== 3'd0) begin fails++; $display("FAIL reset_count: got %0d expected 0", count); end
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_scan_0x22();
        int ae, aw, bc; logic [2:0] c, ce; logic oa;
        run_scan(1'b0, 8'b0010_0010, ae, c, oa, aw, bc, ce);
        checks++; if (ae != 10) begin fails++; $display("FAIL s22_latency: got edge %0d expected 10", ae); end
        checks++; if (c !== 3'd2) begin fails++; $display("FAIL s22_count: got %0d expected 2", c); end
        checks++; if (oa !== 1'b0) begin fails++; $display("FAIL s22_ack1_quiet: got %b expected 0", oa); end
        checks++; if (aw != 1) begin fails++; $display("FAIL s22_ack_width: got %0d expected 1", aw); end
        checks++; if (bc != 10) begin fails++; $display("FAIL s22_busy_cycles: got %0d expected 10", bc); end
        checks++; if (ce !== 3'd2) begin fails++; $display("FAIL s22_count_hold: got %0d expected 2", ce); end
    endtask

    task automatic test_scan_req1_0x01();
        int ae, aw, bc; logic [2:0] c, ce; logic oa;
        run_scan(1'b1, 8'b0000_0001, ae, c, oa, aw, bc, ce);
        checks++; if (ae != 10) begin fails++; $display("FAIL s01_latency: got edge %0d expected 10", ae); end
        checks++; if (c !== 3'd1) begin fails++; $display("FAIL s01_flush_match: got %0d expected 1", c); end
        checks++; if (oa !== 1'b0) begin fails++; $display("FAIL s01_ack0_quiet: got %b expected 0", oa); end
    endtask

    task automatic test_back_to_back();
        int ae, aw, bc; logic [2:0] c, ce; logic oa;
        run_scan(1'b0, 8'b0011_0011, ae, c, oa, aw, bc, ce);
        checks++; if (c !== 3'd2) begin fails++; $display("FAIL s33_discard: got %0d expected 2", c); end
        run_scan(1'b0, 8'h00, ae, c, oa, aw, bc, ce);
        checks++; if (c !== 3'd0) begin fails++; $display("FAIL s00_count: got %0d expected 0", c); end
        checks++; if (ae != 10) begin fails++; $display("FAIL s00_latency: got edge %0d expected 10", ae); end
        run_scan(1'b1, 8'hFF, ae, c, oa, aw, bc, ce);
        checks++; if (c !== 3'd0) begin fails++; $display("FAIL sff_count: got %0d expected 0", c); end
    endtask

    task automatic test_both_req();
        int a0 = 0, a1 = 0, e0 = 0, e1 = 0, both = 0;
        logic [2:0] c0 = 3'd7, c1 = 3'd7;
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        req0 = 1'b1; req1 = 1'b1; data0 = 8'hFF; data1 = 8'h01;
        for (int e = 1; e <= 40; e++) begin
            @(posedge clk);
            @(negedge clk);
            if (ack0 === 1'b1 && ack1 === 1'b1) both++;
            if (ack0 === 1'b1) begin
                a0++;
                if (e0 == 0) begin e0 = e; c0 = count; end
`ifdef ROUND_ROBIN_EN
                req0 = 1'b0;
`endif
            end
            if (ack1 === 1'b1) begin
                a1++;
                if (e1 == 0) begin e1 = e; c1 = count; end
                req1 = 1'b0;
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        for (int i = 0; i < 14; i++) @(negedge clk);
        checks++; if (e0 != 10) begin fails++; $display("FAIL both_ack0_edge: got %0d expected 10", e0); end
        checks++; if (c0 !== 3'd0) begin fails++; $display("FAIL both_ack0_count: got %0d expected 0", c0); end
        checks++; if (both != 0) begin fails++; $display("FAIL both_acks_overlap: got %0d expected 0", both); end
`ifdef ROUND_ROBIN_EN
        checks++; if (e1 != 21) begin fails++; $display("FAIL rr_ack1_edge: got %0d expected 21", e1); end
        checks++; if (c1 !== 3'd1) begin fails++; $display("FAIL rr_ack1_count: got %0d expected 1", c1); end
`else
        checks++; if (a1 != 0) begin fails++; $display("FAIL prio_ack1_starved: got %0d expected 0", a1); end
        checks++; if (a0 != 3) begin fails++; $display("FAIL prio_ack0_repeats: got %0d expected 3", a0); end
`endif
    endtask

    task automatic test_reset_abort();
        int ae, aw, bc; logic [2:0] c, ce; logic oa;
        int acks = 0;
        run_scan(1'b0, 8'b0010_0010, ae, c, oa, aw, bc, ce);
        req0 = 1'b1; data0 = 8'b0010_0010;
        for (int e = 1; e <= 4; e++) @(negedge clk);
        reset = 1'b0;
        req0 = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL abort_busy: got %b expected 0", busy); end
        checks++; if (count !== 3'd0) begin fails++; $display("FAIL abort_count: got %0d expected 0", count); end
        @(negedge clk);
        reset = 1'b1;
        for (int e = 0; e < 12; e++) begin
            @(negedge clk);
            if (ack0 !== 1'b0 || ack1 !== 1'b0) acks++;
        end
        checks++; if (acks != 0) begin fails++; $display("FAIL abort_no_ack: got %0d expected 0", acks); end
        run_scan(1'b0, 8'b0000_0001, ae, c, oa, aw, bc, ce);
        checks++; if (ae != 10) begin fails++; $display("FAIL post_abort_latency: got edge %0d expected 10", ae); end
        checks++; if (c !== 3'd1) begin fails++; $display("FAIL post_abort_count: got %0d expected 1", c); end
    endtask

    initial begin
        test_reset();
        test_scan_0x22();
        test_scan_req1_0x01();
        test_back_to_back();
        test_both_req();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
